// File: rtl/apb_master.sv
// Single-outstanding APB requester: one valid/ready command becomes one APB
// transfer (SETUP then ACCESS), answered by one valid/ready response.
module apb_master #(
  parameter int unsigned DATA    = 32,
  parameter int unsigned ADDR    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [DATA-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DATA-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            psel,
  output logic            penable,
  output logic [ADDR-1:0] paddr,
  output logic            pwrite,
  output logic [DATA-1:0] pwdata,
  input  logic [DATA-1:0] prdata,
  input  logic            pready
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e          r_state,     w_state_nxt;
  logic            r_cmd_ready, w_cmd_ready_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic            r_rsp_err,   w_rsp_err_nxt;
  logic            r_psel,      w_psel_nxt;
  logic            r_penable,   w_penable_nxt;
  logic [ADDR-1:0] r_paddr,     w_paddr_nxt;
  logic            r_pwrite,    w_pwrite_nxt;
  logic [DATA-1:0] r_pwdata,    w_pwdata_nxt;
  logic [CW-1:0]   r_cnt,       w_cnt_nxt;

  // State and every output are flops; the comb block computes their next values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_cnt_nxt       = r_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt     = S_SETUP;
          w_cmd_ready_nxt = 1'b0;
          w_psel_nxt      = 1'b1;
          w_penable_nxt   = 1'b0;
          w_paddr_nxt     = cmd_addr;
          w_pwrite_nxt    = cmd_write;
          w_pwdata_nxt    = cmd_wdata;
          w_cnt_nxt       = '0;
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        // A pready on the final allowed edge still counts as success.
        if (pready) begin
          w_state_nxt     = S_RESP;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt     = S_RESP;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end else if (r_cnt != CW'(TIMEOUT)) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small registered-pready APB slave model.
module tb_apb_master;

  localparam int unsigned DATA    = 32;
  localparam int unsigned ADDR    = 32;
  localparam int unsigned TIMEOUT = 16;

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_write = 1'b0;
  logic [ADDR-1:0] cmd_addr = '0;
  logic [DATA-1:0] cmd_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DATA-1:0] rsp_rdata;
  logic            rsp_err;
  logic            psel;
  logic            penable;
  logic [ADDR-1:0] paddr;
  logic            pwrite;
  logic [DATA-1:0] pwdata;
  logic [DATA-1:0] prdata;
  logic            pready;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(.DATA(DATA), .ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  // Slave model: pready registered, high in the third ACCESS cycle.
  logic            slv_pready = 1'b0;
  logic [DATA-1:0] slv_prdata = '0;
  logic [3:0]      acc_cnt = '0;
  logic            slave_dead = 1'b0;
  logic            force_hi = 1'b0;
  logic [DATA-1:0] mem [0:63];

  assign pready = force_hi | slv_pready;
  assign prdata = slv_prdata;

  always @(posedge pclk) begin
    if (!psel || !penable) begin
      slv_pready <= 1'b0;
      acc_cnt    <= '0;
    end else if (slv_pready) begin
      if (pwrite) mem[paddr[7:2]] <= pwdata;
      slv_pready <= 1'b0;
      acc_cnt    <= '0;
    end else if (!slave_dead) begin
      if (acc_cnt == 4'd1) begin
        slv_pready <= 1'b1;
        slv_prdata <= pwrite ? '0 : mem[paddr[7:2]];
      end else begin
        acc_cnt <= acc_cnt + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Presents a command and returns sampling cycle 1 after the accept edge.
  task automatic accept(input logic w, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL reset_pp: got %b%b expected 00", psel, penable); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got v=%b e=%b expected 0 0", rsp_valid, rsp_err); end
    n_checks++; if (paddr !== '0 || pwdata !== '0 || pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_apb: got a=%h d=%h w=%b expected 0", paddr, pwdata, pwrite); end
    n_checks++; if (rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    presetn = 1'b1;
    tick();
    n_checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin n_fail++; $display("FAIL reset_release: got rdy=%b psel=%b expected 1 0", cmd_ready, psel); end
  endtask

  task automatic test_write_read();
    logic [1:0]      exp_pp [5];
    logic [DATA-1:0] exp_rd;
    exp_pp = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    for (int op = 0; op < 2; op++) begin
      exp_rd = (op == 0) ? 32'h0 : 32'hA5A5_0001;
      accept(op == 0, 32'h10, 32'hA5A5_0001);
      for (int k = 0; k < 5; k++) begin
        n_checks++; if ({psel, penable} !== exp_pp[k]) begin n_fail++; $display("FAIL wr_rd_pp op%0d cyc%0d: got %b%b expected %b", op, k+1, psel, penable, exp_pp[k]); end
        n_checks++; if (rsp_valid !== (k == 4)) begin n_fail++; $display("FAIL wr_rd_latency op%0d cyc%0d: got rsp_valid=%b expected %b", op, k+1, rsp_valid, k == 4); end
        if (psel) begin
          n_checks++; if (paddr !== 32'h10 || pwdata !== 32'hA5A5_0001 || pwrite !== (op == 0)) begin n_fail++; $display("FAIL wr_rd_stable op%0d cyc%0d: got a=%h d=%h w=%b", op, k+1, paddr, pwdata, pwrite); end
        end
        if (k < 4) tick();
      end
      n_checks++; if (rsp_err !== 1'b0 || rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL wr_rd_rsp op%0d: got e=%b d=%h expected 0 %h", op, rsp_err, rsp_rdata, exp_rd); end
      finish_rsp();
      n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_rd_exit op%0d: got v=%b rdy=%b expected 0 1", op, rsp_valid, cmd_ready); end
    end
  endtask

  task automatic test_timeout();
    int pen, cyc;
    pen = 0; cyc = 1;
    slave_dead = 1'b1;
    accept(1'b1, 32'h40, 32'h1111);
    while (!rsp_valid && cyc < 100) begin if (penable) pen++; tick(); cyc++; end
    n_checks++; if (pen !== 16) begin n_fail++; $display("FAIL timeout_penable: got %0d cycles expected 16", pen); end
    n_checks++; if (cyc !== 18) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 18", cyc); end
    n_checks++; if (rsp_err !== 1'b1 || rsp_rdata !== '0 || psel !== 1'b0) begin n_fail++; $display("FAIL timeout_rsp: got e=%b d=%h psel=%b expected 1 0 0", rsp_err, rsp_rdata, psel); end
    finish_rsp();
    slave_dead = 1'b0;
    accept(1'b0, 32'h10, 32'h0);
    wait_rsp(1, cyc);
    n_checks++; if (cyc !== 5 || rsp_err !== 1'b0 || rsp_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL timeout_recover: got cyc=%0d e=%b d=%h expected 5 0 a5a50001", cyc, rsp_err, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_timeout_race();
    slave_dead = 1'b1;
    accept(1'b1, 32'h30, 32'h2222);
    for (int i = 0; i < 16; i++) tick();
    n_checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL race_pre: got pen=%b v=%b expected 1 0", penable, rsp_valid); end
    force_hi = 1'b1;
    tick();
    force_hi = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin n_fail++; $display("FAIL race_success: got v=%b e=%b d=%h expected 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
    slave_dead = 1'b0;
    finish_rsp();
  endtask

  task automatic test_min_latency();
    accept(1'b1, 32'h34, 32'h5);
    tick();
    force_hi = 1'b1;
    n_checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL min_access: got pen=%b v=%b expected 1 0", penable, rsp_valid); end
    tick();
    force_hi = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || psel !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL min_rsp: got v=%b psel=%b e=%b expected 1 0 0", rsp_valid, psel, rsp_err); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int cyc;
    accept(1'b0, 32'h10, 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hDEAD_BEEF;
    wait_rsp(1, cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d expected 5", cyc); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001 || cmd_ready !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b d=%h rdy=%b psel=%b", i, rsp_valid, rsp_rdata, cmd_ready, psel); end
      tick();
    end
    finish_rsp();
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got v=%b rdy=%b psel=%b expected 0 1 0", rsp_valid, cmd_ready, psel); end
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h20) begin n_fail++; $display("FAIL bp_second: got psel=%b pen=%b a=%h expected 1 0 20", psel, penable, paddr); end
    wait_rsp(1, cyc);
    n_checks++; if (cyc !== 5 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin n_fail++; $display("FAIL bp_second_rsp: got cyc=%0d e=%b d=%h expected 5 0 0", cyc, rsp_err, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_spurious();
    int cyc;
    force_hi = 1'b1;
    tick(); tick();
    n_checks++; if (psel !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL spur_idle: got psel=%b v=%b rdy=%b expected 0 0 1", psel, rsp_valid, cmd_ready); end
    accept(1'b0, 32'h10, 32'h0);
    n_checks++; if (psel !== 1'b1 || penable !== 1'b0) begin n_fail++; $display("FAIL spur_setup: got %b%b expected 10", psel, penable); end
    tick();
    force_hi = 1'b0;
    n_checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL spur_access: got pen=%b v=%b expected 1 0", penable, rsp_valid); end
    wait_rsp(2, cyc);
    n_checks++; if (cyc !== 5 || rsp_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL spur_rsp: got cyc=%0d d=%h expected 5 a5a50001", cyc, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    accept(1'b1, 32'h50, 32'h7);
    tick(); tick();
    presetn = 1'b0;
    #1;
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got psel=%b pen=%b v=%b expected 000", psel, penable, rsp_valid); end
    tick();
    presetn = 1'b1;
    tick();
    n_checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got rdy=%b psel=%b expected 1 0", cmd_ready, psel); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale cyc%0d: got v=%b psel=%b expected 0 0", i, rsp_valid, psel); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_timeout();
    test_timeout_race();
    test_min_latency();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
